// File: rtl/csel_pkg.sv
// Shared helpers for the pipelined carry-select adder: geometry derivation,
// parameter legality and the per-stage control bundle.
package csel_pkg;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  function automatic int nblk_of(input int width, input int blk);
    return width / blk;
  endfunction

  function automatic int stages_of(input int width, input int blk, input int bps);
    return ceil_div(width / blk, bps);
  endfunction

  function automatic bit params_ok(input int width, input int blk, input int bps);
    return (blk >= 2) && (bps >= 1) && (width >= blk) && (width % blk == 0);
  endfunction

  // Control travelling alongside each beat: carry into the next block and
  // the operand sign bits needed for the overflow flag at the end.
  typedef struct packed {
    logic sub;
    logic c;
    logic am;
    logic bm;
  } stage_ctl_t;

endpackage

// File: rtl/csel_pipe_adder_if.sv
// Operand-in / result-out handshake bundle for csel_pipe_adder.
interface csel_pipe_adder_if #(parameter int WIDTH = 16);
  import csel_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             ovf;

  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, sum, co, ovf
  );

  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, sum, co, ovf
  );
endinterface

// File: rtl/csel_block.sv
// One carry-select block: both carry-in hypotheses computed up front, the
// real incoming carry only drives the final mux.
module csel_block
  import csel_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] r0, r1;

  assign r0 = {1'b0, a} + {1'b0, b};
  assign r1 = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, 1'b1};

  assign {cout, s} = cin ? r1 : r0;

endmodule

// File: rtl/csel_pipe_adder.sv
// Pipelined carry-select adder/subtractor: BLK-bit blocks, a register stage
// after every BPS blocks, one global advance for valid/ready flow control.
module csel_pipe_adder
  import csel_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLK   = 4,
  parameter int BPS   = 2
) (
  input  logic                clk,
  input  logic                rst,
  csel_pipe_adder_if.slave    io
);

  localparam int NBLK   = nblk_of(WIDTH, BLK);
  localparam int STAGES = stages_of(WIDTH, BLK, BPS);
  localparam int MSB    = WIDTH - 1;

  generate
    if (!params_ok(WIDTH, BLK, BPS)) begin : g_bad_params
      $error("csel_pipe_adder: WIDTH must be a multiple of BLK, BLK>=2, BPS>=1");
    end
  endgenerate

  logic                          adv;
  logic [WIDTH-1:0]              b_eff;
  logic                          c_in;

  logic [STAGES-1:0][WIDTH-1:0]  src_a, src_b, src_s;
  stage_ctl_t [STAGES-1:0]       src_ctl;
  logic [STAGES-1:0][WIDTH-1:0]  a_d, a_q, b_d, b_q, s_d, s_q;
  stage_ctl_t [STAGES-1:0]       ctl_d, ctl_q;
  logic [STAGES-1:0]             vld_d, vld_q;
  logic [STAGES:0]               vld_pipe;

  logic [NBLK-1:0][BLK-1:0]      blk_s;
  logic [STAGES-1:0]             stage_co;

  assign vld_pipe    = {vld_q, io.in_valid};
  assign adv         = !vld_pipe[STAGES] || io.out_ready;
  assign io.in_ready = adv;

  // Stage k's combinational inputs: the raw operands for stage 0, the
  // previous stage's registers otherwise.
  always_comb begin
    b_eff      = io.sub ? ~io.b : io.b;
    c_in       = io.sub | io.ci;
    src_a[0]   = io.a;
    src_b[0]   = b_eff;
    src_s[0]   = '0;
    src_ctl[0] = '{sub: io.sub, c: c_in, am: io.a[MSB], bm: b_eff[MSB]};
    for (int k = 1; k < STAGES; k++) begin
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_s[k]   = s_q[k-1];
      src_ctl[k] = ctl_q[k-1];
    end
  end

  genvar j;
  generate
    for (j = 0; j < NBLK; j++) begin : g_blk
      localparam int K = j / BPS;
      logic ci, co;

      if (j % BPS == 0) begin : g_ci_reg
        assign ci = src_ctl[K].c;
      end else begin : g_ci_chain
        assign ci = g_blk[j-1].co;
      end

      if (j == 0) begin : g_ripple
        assign {co, blk_s[j]} = {1'b0, src_a[K][BLK-1:0]} + {1'b0, src_b[K][BLK-1:0]}
                              + {{BLK{1'b0}}, ci};
      end else begin : g_sel
        csel_block #(.W(BLK)) u_blk (
          .a    (src_a[K][j*BLK +: BLK]),
          .b    (src_b[K][j*BLK +: BLK]),
          .cin  (ci),
          .s    (blk_s[j]),
          .cout (co)
        );
      end

      if ((j % BPS == BPS - 1) || (j == NBLK - 1)) begin : g_last
        assign stage_co[K] = co;
      end
    end
  endgenerate

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      a_d[k]     = src_a[k];
      b_d[k]     = src_b[k];
      s_d[k]     = src_s[k];
      ctl_d[k]   = src_ctl[k];
      ctl_d[k].c = stage_co[k];
      for (int jj = 0; jj < NBLK; jj++) begin
        if (jj / BPS == k) s_d[k][jj*BLK +: BLK] = blk_s[jj];
      end
    end
    vld_d = vld_pipe[STAGES-1:0];
  end

  // Everything moves on adv only, so a stalled output holds bit-for-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      ctl_q <= '0;
    end else if (adv) begin
      vld_q <= vld_d;
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
      ctl_q <= ctl_d;
    end
  end

  assign io.out_valid = vld_pipe[STAGES];
  assign io.sum       = s_q[STAGES-1];
  assign io.co        = ctl_q[STAGES-1].c;
  assign io.ovf       = (ctl_q[STAGES-1].am == ctl_q[STAGES-1].bm) &&
                        (s_q[STAGES-1][MSB] != ctl_q[STAGES-1].am);

  // Operand copies past their last consumer and the carried sub flag.
  logic unused_bits;
  assign unused_bits = ^{a_q, b_q, ctl_q};

endmodule

// File: tb/tb_csel_pipe_adder.sv
// Directed bench for csel_pipe_adder (16/4/2) plus random valid/ready runs on
// the 8/2/1 and 32/4/3 geometries against an integer arithmetic model.
module tb_csel_pipe_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csel_pipe_adder_if #(.WIDTH(16)) if0 ();
  csel_pipe_adder_if #(.WIDTH(8))  if1 ();
  csel_pipe_adder_if #(.WIDTH(32)) if2 ();

  csel_pipe_adder #(.WIDTH(16), .BLK(4), .BPS(2)) u0 (.clk(clk), .rst(rst), .io(if0));
  csel_pipe_adder #(.WIDTH(8),  .BLK(2), .BPS(1)) u1 (.clk(clk), .rst(rst), .io(if1));
  csel_pipe_adder #(.WIDTH(32), .BLK(4), .BPS(3)) u2 (.clk(clk), .rst(rst), .io(if2));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // {ovf, co, sum[31:0]} from plain integer arithmetic on w-bit operands.
  function automatic logic [33:0] model(input int w, input longint a, input longint b,
                                        input bit ci, input bit sub);
    longint mask, be, u, sa, sb, t, hi, lo;
    logic   co, ov;
    mask = (longint'(1) << w) - 1;
    be   = sub ? (~b & mask) : b;
    u    = a + be + (sub ? longint'(1) : longint'(ci));
    co   = ((u >> w) & 1) != 0;
    sa   = ((a >> (w - 1)) & 1) != 0 ? a - (mask + 1) : a;
    sb   = ((b >> (w - 1)) & 1) != 0 ? b - (mask + 1) : b;
    t    = sub ? sa - sb : sa + sb + longint'(ci);
    hi   = (longint'(1) << (w - 1)) - 1;
    lo   = -(hi + 1);
    ov   = (t > hi) || (t < lo);
    return {ov, co, 32'(u & mask)};
  endfunction

  // One isolated beat on the 16-bit unit; expects exactly two cycles latency.
  task automatic tx(input string tag, input logic [15:0] a, input logic [15:0] b,
                    input logic ci, input logic sub,
                    input logic [15:0] es, input logic eco, input logic eov);
    @(negedge clk);
    if0.a = a; if0.b = b; if0.ci = ci; if0.sub = sub; if0.in_valid = 1'b1;
    #1 chk({tag, " in_ready"}, 64'(if0.in_ready), 64'd1);
    @(negedge clk);
    if0.in_valid = 1'b0;
    chk({tag, " early valid"}, 64'(if0.out_valid), 64'd0);
    @(negedge clk);
    chk({tag, " out_valid"}, 64'(if0.out_valid), 64'd1);
    chk({tag, " sum"}, 64'(if0.sum), 64'(es));
    chk({tag, " co"}, 64'(if0.co), 64'(eco));
    chk({tag, " ovf"}, 64'(if0.ovf), 64'(eov));
  endtask

  logic [15:0] bp_a [4] = '{16'h0001, 16'h1000, 16'hFFFF, 16'h0010};
  logic [15:0] bp_b [4] = '{16'h0002, 16'h0FFF, 16'h0002, 16'h0020};
  logic        bp_u [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [15:0] bp_s [4] = '{16'h0003, 16'h1FFF, 16'h0001, 16'hFFF0};
  logic        bp_c [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  logic [33:0] q1 [$];
  logic [33:0] q2 [$];

  initial begin
    int          ni, no;
    logic        stalled;
    logic [15:0] held;
    logic [33:0] e;

    rst = 1'b1;
    if0.in_valid = 1'b0; if0.a = '0; if0.b = '0; if0.ci = 1'b0; if0.sub = 1'b0; if0.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.ci = 1'b0; if1.sub = 1'b0; if1.out_ready = 1'b1;
    if2.in_valid = 1'b0; if2.a = '0; if2.b = '0; if2.ci = 1'b0; if2.sub = 1'b0; if2.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("rst out_valid", 64'(if0.out_valid), 64'd0);
    chk("rst sum", 64'(if0.sum), 64'd0);
    chk("rst co", 64'(if0.co), 64'd0);
    chk("rst ovf", 64'(if0.ovf), 64'd0);
    chk("rst in_ready", 64'(if0.in_ready), 64'd1);
    chk("rst w8 out_valid", 64'(if1.out_valid), 64'd0);
    chk("rst w32 out_valid", 64'(if2.out_valid), 64'd0);

    // Directed arithmetic
    tx("add 00ff+1",   16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    tx("ripple ffff",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    tx("ovf 7fff+1",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    tx("sub 8000-1",   16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    tx("sub 3-5",      16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    tx("add ci",       16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    tx("sub equal",    16'hABCD, 16'hABCD, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    tx("neg ovf",      16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    tx("sub 0-0",      16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Backpressure: four back-to-back beats, output blocked for five cycles
    ni = 0; no = 0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 40 && no < 4; cyc++) begin
      @(negedge clk);
      if0.out_ready = (cyc >= 5);
      if0.in_valid  = (ni < 4);
      if (ni < 4) begin
        if0.a = bp_a[ni]; if0.b = bp_b[ni]; if0.sub = bp_u[ni]; if0.ci = 1'b0;
      end
      #1;
      if (if0.out_valid && !if0.out_ready) begin
        chk("bp in_ready low", 64'(if0.in_ready), 64'd0);
        if (stalled) chk("bp hold sum", 64'(if0.sum), 64'(held));
        held    = if0.sum;
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
      if (if0.out_valid && if0.out_ready) begin
        chk("bp sum", 64'(if0.sum), 64'(bp_s[no]));
        chk("bp co", 64'(if0.co), 64'(bp_c[no]));
        no++;
      end
      if (if0.in_valid && if0.in_ready) ni++;
    end
    chk("bp results", 64'(no), 64'd4);
    chk("bp accepted", 64'(ni), 64'd4);
    @(negedge clk);
    if0.in_valid = 1'b0;
    #1 chk("bp no dup", 64'(if0.out_valid), 64'd0);

    // Reset while beats are in flight
    @(negedge clk);
    if0.out_ready = 1'b1;
    if0.a = 16'h1111; if0.b = 16'h2222; if0.ci = 1'b0; if0.sub = 1'b0; if0.in_valid = 1'b1;
    @(negedge clk);
    if0.a = 16'h3333; if0.b = 16'h4444;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; if0.in_valid = 1'b0;
    #1 chk("midrst out_valid", 64'(if0.out_valid), 64'd0);
    repeat (4) begin
      @(negedge clk);
      #1 chk("midrst flushed", 64'(if0.out_valid), 64'd0);
    end
    tx("post rst", 16'h0101, 16'h0202, 1'b0, 1'b0, 16'h0303, 1'b0, 1'b0);

    // Random valid/ready on the other two geometries
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if1.in_valid  = (cyc < 360) && ($urandom_range(0, 3) != 0);
      if1.a         = 8'($urandom);
      if1.b         = 8'($urandom);
      if1.ci        = 1'($urandom);
      if1.sub       = 1'($urandom);
      if1.out_ready = (cyc >= 360) || ($urandom_range(0, 3) != 0);
      if2.in_valid  = (cyc < 360) && ($urandom_range(0, 3) != 0);
      if2.a         = (cyc % 17 == 0) ? 32'hFFFF_FFFF : $urandom;
      if2.b         = (cyc % 13 == 0) ? 32'h0000_0000 : $urandom;
      if2.ci        = 1'($urandom);
      if2.sub       = 1'($urandom);
      if2.out_ready = (cyc >= 360) || ($urandom_range(0, 2) != 0);
      #1;
      if (if1.out_valid && if1.out_ready) begin
        if (q1.size() == 0) chk("w8 spurious", 64'(if1.out_valid), 64'd0);
        else begin
          e = q1.pop_front();
          chk("w8 sum", 64'(if1.sum), 64'(e[7:0]));
          chk("w8 co", 64'(if1.co), 64'(e[32]));
          chk("w8 ovf", 64'(if1.ovf), 64'(e[33]));
        end
      end
      if (if1.in_valid && if1.in_ready)
        q1.push_back(model(8, longint'(if1.a), longint'(if1.b), if1.ci, if1.sub));
      if (if2.out_valid && if2.out_ready) begin
        if (q2.size() == 0) chk("w32 spurious", 64'(if2.out_valid), 64'd0);
        else begin
          e = q2.pop_front();
          chk("w32 sum", 64'(if2.sum), 64'(e[31:0]));
          chk("w32 co", 64'(if2.co), 64'(e[32]));
          chk("w32 ovf", 64'(if2.ovf), 64'(e[33]));
        end
      end
      if (if2.in_valid && if2.in_ready)
        q2.push_back(model(32, longint'(if2.a), longint'(if2.b), if2.ci, if2.sub));
    end
    chk("w8 drained", 64'(q1.size()), 64'd0);
    chk("w32 drained", 64'(q2.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

endmodule
